// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg: shared constants and payload types for the instruction-fetch stage.
//   FETCH_XLEN      default PC / instruction width
//   FETCH_IMEM_AW   default instruction-ROM word-address width
//   FETCH_RESET_PC  default byte PC loaded on reset
//   NOP_INSTR       canonical no-op encoding (addi x0,x0,0), handy for ROM fill
//   fetch_entry_t   {pc, instr} pair as presented to decode
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned FETCH_XLEN    = 32;
    localparam int unsigned FETCH_IMEM_AW = 10;

    localparam logic [FETCH_XLEN-1:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam logic [FETCH_XLEN-1:0] NOP_INSTR      = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// -----------------------------------------------------------------------------
// fetch_if: bundles the fetch stage's ROM, redirect and decode-handshake signals.
//   imem_pc / imem_instr         ROM word index out, ROM data back (1-cycle latency)
//   redirect_valid / redirect_pc branch/jump target from execute
//   valid / ready / instr / pc   fetch -> decode handshake with payload
// Modports: master = fetch unit side, slave = environment (ROM, execute, decode).
// -----------------------------------------------------------------------------
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN    = FETCH_XLEN,
    parameter int unsigned IMEM_AW = FETCH_IMEM_AW
);

    logic [IMEM_AW-1:0] imem_pc;
    logic [XLEN-1:0]    imem_instr;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               valid;
    logic               ready;
    logic [XLEN-1:0]    instr;
    logic [XLEN-1:0]    pc;

    modport master (
        output imem_pc,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_pc,
        output valid,
        input  ready,
        output instr,
        output pc
    );

    modport slave (
        input  imem_pc,
        output imem_instr,
        output redirect_valid,
        output redirect_pc,
        input  valid,
        output ready,
        input  instr,
        input  pc
    );

endinterface

// File: rtl/fetch_hold_buf.sv
// -----------------------------------------------------------------------------
// fetch_hold_buf: one-entry skid buffer for the ROM's in-flight word plus the
// decode output mux.
//   clk, rst      clock, synchronous active-high reset (empties the buffer)
//   load          capture rsp_entry (only honoured while empty)
//   consume       decode took the held entry (only honoured while full)
//   flush         drop the held entry (redirect); wins over load/consume
//   rsp_v         ROM output this cycle belongs to a live PC
//   rsp_entry     {pc, instr} of the live ROM output
//   hold_v        buffer currently holds an entry
//   out_valid_c   combinational decode valid
//   out_entry_c   combinational decode payload, zero while invalid
// -----------------------------------------------------------------------------
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         consume,
    input  logic         flush,
    input  logic         rsp_v,
    input  fetch_entry_t rsp_entry,
    output logic         hold_v,
    output logic         out_valid_c,
    output fetch_entry_t out_entry_c
);

    typedef enum logic {
        HB_EMPTY = 1'b0,
        HB_FULL  = 1'b1
    } hb_state_t;

    hb_state_t    state_q, state_d;
    fetch_entry_t entry_q, entry_d;

    // State and payload registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HB_EMPTY;
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
        end
    end

    // Next-state: load while empty, release on consume, flush overrides both.
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        case (state_q)
            HB_EMPTY: begin
                if (load) begin
                    state_d = HB_FULL;
                    entry_d = rsp_entry;
                end
            end
            HB_FULL: begin
                if (consume) begin
                    state_d = HB_EMPTY;
                end
            end
            default: state_d = HB_EMPTY;
        endcase
        if (flush) begin
            state_d = HB_EMPTY;
        end
    end

    assign hold_v = (state_q == HB_FULL);

    // Held entry is older than the ROM word, so it goes first.
    always_comb begin
        out_valid_c = hold_v | rsp_v;
        out_entry_c = '0;
        if (hold_v) begin
            out_entry_c = entry_q;
        end else if (rsp_v) begin
            out_entry_c = rsp_entry;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit: instruction-fetch stage in front of a 1-cycle-latency instruction
// ROM. Owns the PC, tracks which PC each returning ROM word belongs to, and
// presents {pc, instr} to decode over a valid/ready handshake. A one-entry hold
// buffer absorbs the in-flight ROM word during decode stalls so stall release
// is bubble-free.
//   clock_i       clock, all state on posedge
//   reset_ni      synchronous reset, asserted HIGH despite the name
//   bus           fetch_if.master: ROM index/data, redirect, decode handshake
// Optional build macro FETCH_PERF_CNT_EN adds:
//   perf_fetch_o  count of handshakes (valid & ready), wraps at 2^32
//   perf_stall_o  count of cycles with valid & !ready, wraps at 2^32
// Parameters XLEN/IMEM_AW must match the fetch_pkg defaults used by fetch_entry_t.
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = FETCH_XLEN,
    parameter int unsigned     IMEM_AW  = FETCH_IMEM_AW,
    parameter logic [XLEN-1:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clock_i,
    input  logic        reset_ni,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_stall_o,
`endif
    fetch_if.master     bus
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic            rsp_v_q, rsp_v_d;

    logic            hold_v;
    logic            hold_load;
    logic            hold_consume;
    logic            hold_flush;
    logic            out_valid_c;
    fetch_entry_t    rsp_entry_c;
    fetch_entry_t    out_entry_c;

    assign rsp_entry_c.pc    = rsp_pc_q;
    assign rsp_entry_c.instr = bus.imem_instr;

    // PC and response-tracking registers.
    always_ff @(posedge clock_i) begin
        if (reset_ni) begin
            pc_q     <= RESET_PC;
            rsp_v_q  <= 1'b0;
            rsp_pc_q <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_v_q  <= rsp_v_d;
            rsp_pc_q <= rsp_pc_d;
        end
    end

    // Next PC / response tracking. While stalled the PC is frozen so the ROM
    // keeps re-reading the same index and the rsp slot stays valid.
    always_comb begin
        pc_d         = pc_q;
        rsp_v_d      = rsp_v_q;
        rsp_pc_d     = rsp_pc_q;
        hold_load    = 1'b0;
        hold_consume = 1'b0;
        hold_flush   = 1'b0;
        if (bus.redirect_valid) begin
            pc_d       = bus.redirect_pc & ~XLEN'(3);
            rsp_v_d    = 1'b0;
            hold_flush = 1'b1;
        end else if (!hold_v) begin
            rsp_v_d  = 1'b1;
            rsp_pc_d = pc_q;
            if (!out_valid_c || bus.ready) begin
                pc_d = pc_q + XLEN'(4);
            end else begin
                hold_load = 1'b1;
            end
        end else if (bus.ready) begin
            hold_consume = 1'b1;
            pc_d         = pc_q + XLEN'(4);
            rsp_pc_d     = pc_q;
        end
    end

    fetch_hold_buf u_hold_buf (
        .clk         (clock_i),
        .rst         (reset_ni),
        .load        (hold_load),
        .consume     (hold_consume),
        .flush       (hold_flush),
        .rsp_v       (rsp_v_q),
        .rsp_entry   (rsp_entry_c),
        .hold_v      (hold_v),
        .out_valid_c (out_valid_c),
        .out_entry_c (out_entry_c)
    );

    assign bus.imem_pc = pc_q[IMEM_AW+1:2];
    assign bus.valid   = out_valid_c;
    assign bus.pc      = out_entry_c.pc;
    assign bus.instr   = out_entry_c.instr;

`ifdef FETCH_PERF_CNT_EN
    // Handshake and stall counters.
    always_ff @(posedge clock_i) begin
        if (reset_ni) begin
            perf_fetch_o <= '0;
            perf_stall_o <= '0;
        end else begin
            if (out_valid_c && bus.ready) begin
                perf_fetch_o <= perf_fetch_o + 32'd1;
            end
            if (out_valid_c && !bus.ready) begin
                perf_stall_o <= perf_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule
